// File: rtl/imem_boot_pkg.sv
// imem_boot_pkg: boot loader FSM states and delay-counter width shared by the imem boot loader files
package imem_boot_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} boot_state_t;
  localparam int DLY_W = 4;
endpackage

// File: rtl/imem_boot_delay_cnt.sv
// imem_boot_delay_cnt: loadable down-counter whose expire pulse marks the last cycle of an enabled countdown
module imem_boot_delay_cnt
  import imem_boot_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DLY_W-1:0] load_val,
  input  logic             en,
  output logic             expire
);
  logic [DLY_W-1:0] cnt;
  always_ff @(posedge clk)
    if (!reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign expire = en && !load && cnt == '0;
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams words into imem from addr 0 under core reset, releases core after BOOT_DELAY (IMEM_BOOT_LOADER_CKSUM_EN adds checksum gate)
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int BOOT_DELAY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef IMEM_BOOT_LOADER_CKSUM_EN
  ,
  input  logic [DATA_W-1:0] cksum_exp,
  output logic              cksum_ok
`endif
);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;
  boot_state_t state, state_n;
  logic [ADDR_W:0] total, cnt;
  logic [ADDR_W-1:0] addr;
  logic hs, legal, idle_or_run, start_ok, start_bad, last, expire, pass;
  assign hs          = s_valid && s_ready;
  assign legal       = word_count != '0 && word_count <= DEPTH;
  assign idle_or_run = state == IDLE || state == RUN;
  assign start_ok    = load_start && idle_or_run && legal;
  assign start_bad   = load_start && idle_or_run && !legal;
  assign last        = hs && cnt + 1'b1 == total;
  assign s_ready     = state == LOAD;
  assign busy        = state == LOAD || state == FLUSH;
  assign done        = state == RUN;
  assign core_rst    = state != RUN;
`ifdef IMEM_BOOT_LOADER_CKSUM_EN
  logic [DATA_W-1:0] sum, exp_sum;
  assign pass = sum == exp_sum;
`else
  assign pass = 1'b1;
`endif
  imem_boot_delay_cnt u_dly (
    .clk      (clk),
    .reset    (reset),
    .load     (last),
    .load_val (DLY_W'(BOOT_DELAY - 1)),
    .en       (state == FLUSH),
    .expire   (expire)
  );
  always_comb
    state_n = start_ok ? LOAD : last ? FLUSH : expire ? (pass ? RUN : IDLE) : state;
  always_ff @(posedge clk)
    state <= !reset ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (!reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      err        <= 1'b0;
      total      <= '0;
      cnt        <= '0;
      addr       <= '0;
`ifdef IMEM_BOOT_LOADER_CKSUM_EN
      sum        <= '0;
      exp_sum    <= '0;
      cksum_ok   <= 1'b0;
`endif
    end else begin
      imem_we <= hs;
      if (hs) begin
        imem_addr  <= addr;
        imem_wdata <= s_data;
        addr       <= addr + 1'b1;
        cnt        <= cnt + 1'b1;
`ifdef IMEM_BOOT_LOADER_CKSUM_EN
        sum        <= sum + s_data;
`endif
      end
      if (start_ok) begin
        total <= word_count;
        cnt   <= '0;
        addr  <= '0;
        err   <= 1'b0;
`ifdef IMEM_BOOT_LOADER_CKSUM_EN
        sum      <= '0;
        exp_sum  <= cksum_exp;
        cksum_ok <= 1'b0;
`endif
      end
      if (start_bad) err <= 1'b1;
`ifdef IMEM_BOOT_LOADER_CKSUM_EN
      if (expire) begin
        cksum_ok <= pass;
        if (!pass) err <= 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: table-driven load vectors plus reset/checksum sequences, imem writes checked against a scoreboard queue
module tb_imem_boot_loader;
  logic clk = 1'b0, reset = 1'b0, load_start = 1'b0, s_valid = 1'b0;
  logic [6:0] word_count = '0;
  logic [31:0] s_data = '0;
  logic s_ready, imem_we, core_rst, busy, done, err;
  logic [5:0] imem_addr;
  logic [31:0] imem_wdata;
`ifdef IMEM_BOOT_LOADER_CKSUM_EN
  logic [31:0] cksum_exp = '0;
  logic cksum_ok;
`endif
  int checks = 0, errors = 0, wr_cnt = 0;
  logic [37:0] sb[$];
  logic [31:0] words[64];
  typedef struct {
    logic [6:0] wc;
    bit gaps;
    bit exp_err;
    bit exp_run;
  } vec_t;
  vec_t vecs[8];
  imem_boot_loader dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .word_count (word_count),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .busy       (busy),
    .done       (done),
    .err        (err)
`ifdef IMEM_BOOT_LOADER_CKSUM_EN
    ,
    .cksum_exp  (cksum_exp),
    .cksum_ok   (cksum_ok)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (imem_we) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write got addr %0h data %0h want no write", imem_addr, imem_wdata);
      end else chk("imem_write", 64'({imem_addr, imem_wdata}), 64'(sb.pop_front()));
    end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic [6:0] wc);
    load_start = 1'b1;
    word_count = wc;
    tick;
    load_start = 1'b0;
  endtask
  task automatic feed(input int n, input bit gaps);
    logic [5:0] a = '0;
    int i = 0;
    bit ph = 1'b1;
    while (i < n) begin
      s_valid = ph;
      s_data  = ph ? words[i] : 32'hDEAD_BEEF;
      if (ph) begin
        sb.push_back({a, words[i]});
        a++;
        i++;
      end
      tick;
      if (gaps) ph = !ph;
    end
    s_valid = 1'b0;
  endtask
  task automatic wait_flush(output int k);
    k = 0;
    while (busy && k < 20) begin
      tick;
      k++;
    end
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    chk({tag, "_imem_we"}, 64'(imem_we), 64'd0);
    chk({tag, "_imem_addr"}, 64'(imem_addr), 64'd0);
    chk({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
    chk({tag, "_core_rst"}, 64'(core_rst), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
  initial begin
    int k, w0;
    tick;
    tick;
    check_reset("por");
    reset = 1'b1;
    tick;
    vecs[0] = '{7'd0,   1'b0, 1'b1, 1'b0};
    vecs[1] = '{7'd65,  1'b0, 1'b1, 1'b0};
    vecs[2] = '{7'd3,   1'b0, 1'b0, 1'b1};
    vecs[3] = '{7'd4,   1'b1, 1'b0, 1'b1};
    vecs[4] = '{7'd1,   1'b0, 1'b0, 1'b1};
    vecs[5] = '{7'd64,  1'b0, 1'b0, 1'b1};
    vecs[6] = '{7'd0,   1'b0, 1'b1, 1'b1};
    vecs[7] = '{7'd127, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 64; j++) words[j] = $urandom;
      if (i == 2) begin
        words[0] = 32'h0050_0093;
        words[1] = 32'h0010_0113;
        words[2] = 32'h0020_81B3;
      end
      w0 = wr_cnt;
      if (vecs[i].exp_err) begin
        s_valid = 1'b1;
        s_data  = $urandom;
        start(vecs[i].wc);
        tick;
        tick;
        s_valid = 1'b0;
        chk($sformatf("vec%0d_err", i), 64'(err), 64'd1);
        chk($sformatf("vec%0d_busy", i), 64'(busy), 64'd0);
        chk($sformatf("vec%0d_done", i), 64'(done), 64'(vecs[i].exp_run));
        chk($sformatf("vec%0d_core_rst", i), 64'(core_rst), 64'(!vecs[i].exp_run));
        chk($sformatf("vec%0d_writes", i), 64'(wr_cnt - w0), 64'd0);
      end else begin
        start(vecs[i].wc);
        chk($sformatf("vec%0d_hold", i), 64'(core_rst), 64'd1);
        chk($sformatf("vec%0d_done_low", i), 64'(done), 64'd0);
        chk($sformatf("vec%0d_s_ready", i), 64'(s_ready), 64'd1);
        chk($sformatf("vec%0d_err_clr", i), 64'(err), 64'd0);
        feed(int'(vecs[i].wc), vecs[i].gaps);
        wait_flush(k);
        chk($sformatf("vec%0d_delay", i), 64'(k), 64'd4);
        chk($sformatf("vec%0d_done", i), 64'(done), 64'd1);
        chk($sformatf("vec%0d_release", i), 64'(core_rst), 64'd0);
        chk($sformatf("vec%0d_writes", i), 64'(wr_cnt - w0), 64'(vecs[i].wc));
        chk($sformatf("vec%0d_sb_drained", i), 64'(sb.size()), 64'd0);
      end
    end
    for (int j = 0; j < 64; j++) words[j] = $urandom;
    start(7'd5);
    feed(2, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    tick;
    check_reset("midload");
    chk("midload_sb", 64'(sb.size()), 64'd0);
    reset = 1'b1;
    tick;
    for (int j = 0; j < 64; j++) words[j] = $urandom;
    w0 = wr_cnt;
    start(7'd2);
    feed(2, 1'b0);
    wait_flush(k);
    chk("restart_delay", 64'(k), 64'd4);
    chk("restart_done", 64'(done), 64'd1);
    chk("restart_writes", 64'(wr_cnt - w0), 64'd2);
`ifdef IMEM_BOOT_LOADER_CKSUM_EN
    words[0] = 32'd1;
    words[1] = 32'd2;
    words[2] = 32'd3;
    cksum_exp = 32'd6;
    start(7'd3);
    feed(3, 1'b0);
    wait_flush(k);
    chk("cksum_ok_delay", 64'(k), 64'd4);
    chk("cksum_ok_done", 64'(done), 64'd1);
    chk("cksum_ok_flag", 64'(cksum_ok), 64'd1);
    chk("cksum_ok_err", 64'(err), 64'd0);
    cksum_exp = 32'd7;
    start(7'd3);
    feed(3, 1'b0);
    wait_flush(k);
    chk("cksum_bad_delay", 64'(k), 64'd4);
    chk("cksum_bad_err", 64'(err), 64'd1);
    chk("cksum_bad_flag", 64'(cksum_ok), 64'd0);
    chk("cksum_bad_done", 64'(done), 64'd0);
    chk("cksum_bad_core_rst", 64'(core_rst), 64'd1);
`endif
    tick;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
